// File: rtl/idli_sqi_burst_ctrl_m_pkg.sv
// Shared types and constants for the SQI burst controller.
// Holds the FSM state encoding, pad-direction encoding and SQI opcodes.
package idli_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GUARD} sqi_state_t;

  typedef enum logic {SQI_MODE_IN = 1'b0, SQI_MODE_OUT = 1'b1} sqi_mode_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // States during which a chip select is held low and SCK runs.
  function automatic logic sqi_active(input sqi_state_t s);
    return (s == CMD) || (s == ADDR) || (s == DUMMY) || (s == DATA);
  endfunction

  function automatic logic [3:0] cmd_nibble(input logic wr, input logic lo);
    logic [7:0] c;
    c = wr ? SQI_CMD_WRITE : SQI_CMD_READ;
    return lo ? c[3:0] : c[7:4];
  endfunction

endpackage

// File: rtl/idli_sqi_burst_ctrl_m_if.sv
// Core request/data handshake plus SQI pad signals of the burst controller.
// slave = controller side, master = core/pad side.
interface idli_sqi_burst_ctrl_m_if #(
  parameter int ADDR_NIBBLES = 4,
  parameter int NUM_CS       = 2,
  parameter int BURST_W      = 4
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                      i_sqi_req;
  logic                      i_sqi_wr;
  logic [CS_W-1:0]           i_sqi_cs_sel;
  logic [4*ADDR_NIBBLES-1:0] i_sqi_addr;
  logic [BURST_W-1:0]        i_sqi_len;
  logic                      i_sqi_abort;
  logic                      o_sqi_ack;
  logic                      o_sqi_err;
  logic                      o_sqi_busy;
  logic                      o_sqi_wr_rdy;
  logic [3:0]                i_sqi_wdata;
  logic                      o_sqi_rd_vld;
  logic [3:0]                o_sqi_rdata;
  logic                      o_sqi_last;
  logic                      o_sqi_done;
  logic                      o_sqi_sck;
  logic [NUM_CS-1:0]         o_sqi_cs_n;
  logic                      o_sqi_mode;
  logic [3:0]                o_sqi_data;
  logic [3:0]                i_sqi_data;

  modport slave (
    input  i_sqi_req, i_sqi_wr, i_sqi_cs_sel, i_sqi_addr, i_sqi_len, i_sqi_abort,
    input  i_sqi_wdata, i_sqi_data,
    output o_sqi_ack, o_sqi_err, o_sqi_busy, o_sqi_wr_rdy, o_sqi_rd_vld, o_sqi_rdata,
    output o_sqi_last, o_sqi_done, o_sqi_sck, o_sqi_cs_n, o_sqi_mode, o_sqi_data
  );

  modport master (
    output i_sqi_req, i_sqi_wr, i_sqi_cs_sel, i_sqi_addr, i_sqi_len, i_sqi_abort,
    output i_sqi_wdata, i_sqi_data,
    input  o_sqi_ack, o_sqi_err, o_sqi_busy, o_sqi_wr_rdy, o_sqi_rd_vld, o_sqi_rdata,
    input  o_sqi_last, o_sqi_done, o_sqi_sck, o_sqi_cs_n, o_sqi_mode, o_sqi_data
  );

endinterface

// File: rtl/idli_sqi_burst_ctrl_m_sck_gate.sv
// Glitch-free SCK gate: enable is captured while gck is low, then ANDed with gck.
// The enable for cycle N is captured on the falling edge inside cycle N-1.
module idli_sqi_sck_gate_m (
  input  logic gck_i,
  input  logic rst_n_i,
  input  logic en_d_i,
  output logic sck_o
);

  logic en_q;

  always_ff @(negedge gck_i or negedge rst_n_i) begin
    if (!rst_n_i) en_q <= 1'b0;
    else          en_q <= en_d_i;
  end

  assign sck_o = gck_i & en_q;

endmodule

// File: rtl/idli_sqi_burst_ctrl_m.sv
// SQI SRAM burst controller: CMD, ADDR, DUMMY (reads) and nibble-serial DATA phases.
// Request is acked in IDLE only; one GUARD cycle with CS high follows every transfer.
module idli_sqi_burst_ctrl_m
  import idli_pkg::*;
#(
  parameter int ADDR_NIBBLES = 4,
  parameter int NUM_CS       = 2,
  parameter int BURST_W      = 4,
  parameter int DUMMY_CYCLES = 2
) (
  input logic                 i_sqi_gck,
  input logic                 i_sqi_rst_n,
  idli_sqi_burst_ctrl_m_if.slave sqi
);

  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int AW   = 4 * ADDR_NIBBLES;
  localparam int NMAX = max3(ADDR_NIBBLES, DUMMY_CYCLES, 4);
  localparam int NCW  = $clog2(NMAX);

  sqi_state_t         state_q, state_d;
  logic [NCW-1:0]     nib_q, nib_d;
  logic [BURST_W-1:0] word_q, word_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               wr_q, wr_d;
  logic [CS_W-1:0]    cs_q, cs_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [NUM_CS-1:0]  cs_n_q, cs_n_d;
  sqi_mode_t          mode_q, mode_d;
  logic               sck_en_d;
  logic               cs_ok, ack, err, wr_rdy, rd_vld, last;
  logic [3:0]         data_out;

  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    word_d   = word_q;
    len_d    = len_q;
    wr_d     = wr_q;
    cs_d     = cs_q;
    addr_d   = addr_q;
    ack      = 1'b0;
    err      = 1'b0;
    wr_rdy   = 1'b0;
    rd_vld   = 1'b0;
    last     = 1'b0;
    data_out = 4'h0;
    cs_ok    = 32'(sqi.i_sqi_cs_sel) < NUM_CS;

    case (state_q)
      IDLE: begin
        if (sqi.i_sqi_req) begin
          if (cs_ok) begin
            ack     = 1'b1;
            wr_d    = sqi.i_sqi_wr;
            cs_d    = sqi.i_sqi_cs_sel;
            addr_d  = sqi.i_sqi_addr;
            len_d   = sqi.i_sqi_len;
            nib_d   = '0;
            word_d  = '0;
            state_d = CMD;
          end else begin
            err = 1'b1;
          end
        end
      end
      CMD: begin
        data_out = cmd_nibble(wr_q, nib_q[0]);
        if (nib_q[0]) begin
          nib_d   = '0;
          state_d = ADDR;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      ADDR: begin
        data_out = addr_q[AW-1 -: 4];
        addr_d   = addr_q << 4;
        if (nib_q == NCW'(ADDR_NIBBLES - 1)) begin
          nib_d   = '0;
          state_d = wr_q ? DATA : DUMMY;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      DUMMY: begin
        if (nib_q == NCW'(DUMMY_CYCLES - 1)) begin
          nib_d   = '0;
          state_d = DATA;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      DATA: begin
        wr_rdy   = wr_q;
        rd_vld   = ~wr_q;
        data_out = sqi.i_sqi_wdata;
        last     = (nib_q == NCW'(3)) && (word_q == len_q);
        if (nib_q == NCW'(3)) begin
          nib_d = '0;
          // Word counter stops at len so an all-ones length never wraps.
          if (last) state_d = GUARD;
          else      word_d  = word_q + 1'b1;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (sqi.i_sqi_abort && sqi_active(state_q)) state_d = GUARD;

    cs_n_d   = sqi_active(state_d) ? ~(NUM_CS'(1) << cs_d) : '1;
    mode_d   = ((state_d == DUMMY) || (state_d == DATA && !wr_d)) ? SQI_MODE_IN : SQI_MODE_OUT;
    sck_en_d = sqi_active(state_d);
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q <= IDLE;
      nib_q   <= '0;
      word_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      cs_q    <= '0;
      addr_q  <= '0;
      cs_n_q  <= '1;
      mode_q  <= SQI_MODE_OUT;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      word_q  <= word_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      cs_n_q  <= cs_n_d;
      mode_q  <= mode_d;
    end
  end

  idli_sqi_sck_gate_m u_sck_gate (
    .gck_i   (i_sqi_gck),
    .rst_n_i (i_sqi_rst_n),
    .en_d_i  (sck_en_d),
    .sck_o   (sqi.o_sqi_sck)
  );

  assign sqi.o_sqi_ack    = ack;
  assign sqi.o_sqi_err    = err;
  assign sqi.o_sqi_busy   = (state_q != IDLE);
  assign sqi.o_sqi_wr_rdy = wr_rdy;
  assign sqi.o_sqi_rd_vld = rd_vld;
  assign sqi.o_sqi_rdata  = sqi.i_sqi_data;
  assign sqi.o_sqi_last   = last;
  assign sqi.o_sqi_done   = (state_q == GUARD);
  assign sqi.o_sqi_cs_n   = cs_n_q;
  assign sqi.o_sqi_mode   = mode_q;
  assign sqi.o_sqi_data   = data_out;

endmodule

// File: tb/tb_idli_sqi_burst_ctrl_m.sv
// Bench for idli_sqi_burst_ctrl_m: per-cycle expected pad/handshake trace built from
// the transaction rules, directed cases first then randomized bursts and aborts.
module tb_idli_sqi_burst_ctrl_m;

  localparam int AN = 4;
  localparam int BW = 4;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  idli_sqi_burst_ctrl_m_if #(.ADDR_NIBBLES(AN), .NUM_CS(2), .BURST_W(BW)) a ();
  idli_sqi_burst_ctrl_m_if #(.ADDR_NIBBLES(AN), .NUM_CS(3), .BURST_W(BW)) b ();

  idli_sqi_burst_ctrl_m #(.ADDR_NIBBLES(AN), .NUM_CS(2), .BURST_W(BW), .DUMMY_CYCLES(DC)) u_dut (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .sqi(a));
  idli_sqi_burst_ctrl_m #(.ADDR_NIBBLES(AN), .NUM_CS(3), .BURST_W(BW), .DUMMY_CYCLES(DC)) u_dut3 (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .sqi(b));

  typedef struct packed {
    logic       act;
    logic       mode;
    logic       chk_d;
    logic [3:0] dat;
    logic       wr_rdy;
    logic       rd_vld;
    logic       last;
    logic       done;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [3:0] wd[64];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t mk(input logic act, input logic mode, input logic chk_d,
                              input logic [3:0] dat, input logic wr_rdy, input logic rd_vld,
                              input logic last, input logic done);
    cyc_t c;
    c = '{act, mode, chk_d, dat, wr_rdy, rd_vld, last, done};
    return c;
  endfunction

  // Expected pad trace of one transaction, cycle by cycle, starting the cycle after ack.
  task automatic build(input logic wr, input logic [15:0] addr, input int len, input int abort_at);
    logic [7:0] cmd;
    int nd;
    cmd = wr ? 8'h02 : 8'h03;
    exp_q.delete();
    exp_q.push_back(mk(1, 1, 1, cmd[7:4], 0, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 1, cmd[3:0], 0, 0, 0, 0));
    for (int i = 0; i < AN; i++) exp_q.push_back(mk(1, 1, 1, addr[4*(AN-1-i) +: 4], 0, 0, 0, 0));
    if (!wr) for (int i = 0; i < DC; i++) exp_q.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 0));
    nd = 4 * (len + 1);
    for (int i = 0; i < nd; i++) exp_q.push_back(mk(1, wr, wr, wd[i], wr, !wr, i == nd - 1, 0));
    if (abort_at >= 0) while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
    exp_q.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 1));
  endtask

  task automatic run(input logic wr, input int cs, input logic [15:0] addr, input int len,
                     input int abort_at, input logic keep);
    int n_cs, n_dat, n_done, pre, act;
    logic [3:0] p;
    logic [1:0] ecs;
    cyc_t e;
    build(wr, addr, len, abort_at);
    @(posedge clk); #1;
    a.i_sqi_req = 1'b1; a.i_sqi_wr = wr; a.i_sqi_cs_sel = 1'(cs);
    a.i_sqi_addr = addr; a.i_sqi_len = 4'(len); a.i_sqi_abort = 1'b0;
    #1;
    chk("req_ack", a.o_sqi_ack, 1);
    chk("req_err", a.o_sqi_err, 0);
    chk("req_busy", a.o_sqi_busy, 0);
    chk("req_cs_n", a.o_sqi_cs_n, 2'b11);
    n_cs = 0; n_dat = 0; n_done = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      @(posedge clk); #1;
      a.i_sqi_req   = keep;
      a.i_sqi_abort = (i == abort_at);
      p = 4'($urandom);
      a.i_sqi_data  = p;
      a.i_sqi_wdata = e.wr_rdy ? e.dat : 4'($urandom);
      #1;
      ecs = e.act ? ~(2'b01 << cs) : 2'b11;
      chk("cs_n", a.o_sqi_cs_n, ecs);
      chk("mode", a.o_sqi_mode, e.mode);
      chk("sck", a.o_sqi_sck, e.act);
      chk("wr_rdy", a.o_sqi_wr_rdy, e.wr_rdy);
      chk("rd_vld", a.o_sqi_rd_vld, e.rd_vld);
      chk("last", a.o_sqi_last, e.last);
      chk("done", a.o_sqi_done, e.done);
      chk("busy", a.o_sqi_busy, 1);
      chk("no_ack", a.o_sqi_ack, 0);
      if (e.chk_d) chk("data", a.o_sqi_data, e.dat);
      if (e.rd_vld) chk("rdata", a.o_sqi_rdata, p);
      n_cs   += int'(a.o_sqi_cs_n != 2'b11);
      n_dat  += int'(a.o_sqi_wr_rdy | a.o_sqi_rd_vld);
      n_done += int'(a.o_sqi_done);
    end
    a.i_sqi_abort = 1'b0;
    pre = 2 + AN + (wr ? 0 : DC);
    act = (abort_at >= 0 && abort_at < pre + 4 * (len + 1)) ? abort_at + 1 : pre + 4 * (len + 1);
    chk("cs_low_cycles", n_cs, act);
    chk("data_beats", n_dat, (act > pre) ? act - pre : 0);
    chk("done_count", n_done, 1);
  endtask

  initial begin
    logic wr;
    int cs, len, ab;
    logic [15:0] addr;
    rst_n = 1'b0;
    a.i_sqi_req = 0; a.i_sqi_wr = 0; a.i_sqi_cs_sel = '0; a.i_sqi_addr = '0; a.i_sqi_len = '0;
    a.i_sqi_abort = 0; a.i_sqi_wdata = '0; a.i_sqi_data = '0;
    b.i_sqi_req = 0; b.i_sqi_wr = 0; b.i_sqi_cs_sel = '0; b.i_sqi_addr = '0; b.i_sqi_len = '0;
    b.i_sqi_abort = 0; b.i_sqi_wdata = '0; b.i_sqi_data = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cs_n", a.o_sqi_cs_n, 2'b11);
    chk("rst_mode", a.o_sqi_mode, 1);
    chk("rst_sck", a.o_sqi_sck, 0);
    chk("rst_busy", a.o_sqi_busy, 0);
    chk("rst_done", a.o_sqi_done, 0);
    chk("rst_vld", {a.o_sqi_wr_rdy, a.o_sqi_rd_vld, a.o_sqi_last, a.o_sqi_ack, a.o_sqi_err}, 0);
    chk("rst_cs_n3", b.o_sqi_cs_n, 3'b111);
    @(negedge clk) rst_n = 1'b1;

    // Single-word write with fixed data nibbles.
    wd[0] = 4'hA; wd[1] = 4'hB; wd[2] = 4'hC; wd[3] = 4'hD;
    run(1'b1, 0, 16'h1234, 0, -1, 1'b0);
    // Two-word read on the second chip select.
    run(1'b0, 1, 16'h00F0, 1, -1, 1'b0);
    // Abort on the third data cycle of a four-word write.
    for (int k = 0; k < 64; k++) wd[k] = 4'($urandom);
    run(1'b1, 0, 16'h5A5A, 3, 2 + AN + 2, 1'b0);
    // Maximum burst length.
    run(1'b1, 1, 16'hFFFF, 15, -1, 1'b0);
    // Two reads with req held: second ack falls on the cycle after GUARD.
    run(1'b0, 1, 16'h0420, 0, -1, 1'b1);
    run(1'b0, 1, 16'h0420, 0, -1, 1'b0);

    // Out-of-range chip select on the three-CS instance.
    @(posedge clk); #1;
    b.i_sqi_req = 1'b1; b.i_sqi_cs_sel = 2'd3;
    #1;
    chk("err3_pulse", b.o_sqi_err, 1);
    chk("err3_ack", b.o_sqi_ack, 0);
    @(posedge clk); #2;
    chk("err3_busy", b.o_sqi_busy, 0);
    chk("err3_cs_n", b.o_sqi_cs_n, 3'b111);
    b.i_sqi_req = 1'b0;
    #1;
    chk("err3_clear", b.o_sqi_err, 0);

    // Reset in the middle of the address phase.
    @(posedge clk); #1;
    a.i_sqi_req = 1'b1; a.i_sqi_wr = 1'b1; a.i_sqi_cs_sel = 1'b0; a.i_sqi_addr = 16'hBEEF; a.i_sqi_len = '0;
    @(posedge clk); #1;
    a.i_sqi_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_cs_n", a.o_sqi_cs_n, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n", a.o_sqi_cs_n, 2'b11);
    chk("arst_mode", a.o_sqi_mode, 1);
    chk("arst_sck", a.o_sqi_sck, 0);
    chk("arst_busy", a.o_sqi_busy, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run(1'b1, 0, 16'h0001, 0, -1, 1'b0);

    // Randomized bursts, some aborted at any phase (including GUARD, where it is ignored).
    for (int t = 0; t < 10; t++) begin
      wr   = 1'($urandom_range(0, 1));
      cs   = $urandom_range(0, 1);
      addr = 16'($urandom);
      len  = $urandom_range(0, 15);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 + AN + DC + 4 * (len + 1) - 1) : -1;
      for (int k = 0; k < 64; k++) wd[k] = 4'($urandom);
      run(wr, cs, addr, len, ab, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
